// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bundle between the instruction fetch queue, instruction memory,
// the redirect source and the decode stage.
//
// Handshake rule used by every channel in this bundle: a transfer happens in a
// cycle where valid and ready are both 1. The producer holds valid and its
// payload steady until that cycle. The only exception is a redirect, which may
// withdraw or change an unaccepted fetch request. imem_resp_valid and
// redirect_valid have no ready; they are accepted in the cycle they are high.
interface instr_fetch_queue_if #(
    parameter int PC_BITS = 32
);
    logic               imem_req_valid;
    logic [PC_BITS-1:0] imem_req_addr;
    logic               imem_req_ready;
    logic               imem_resp_valid;
    logic [31:0]        imem_resp_data;
    logic               redirect_valid;
    logic [PC_BITS-1:0] redirect_pc;
    logic               instr_valid;
    logic [31:0]        instr;
    logic [PC_BITS-1:0] instr_pc;
    logic               instr_ready;

    // Fetch queue side
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, instr_ready
    );

    // Memory / control / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches, buffers returned
// words with their PCs, and hands them to decode. A redirect flushes the
// queue, restarts fetch at the new PC and marks all outstanding requests
// stale so their responses are dropped.
module instr_fetch_queue #(
    parameter int                 PC_BITS  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    instr_fetch_queue_if.master    bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // Outstanding/stale counters get extra headroom: repeated redirects with
    // a slow memory can stack stale requests on top of a full credit window.
    localparam int IF_W  = PTR_W + 4;
    localparam int OCC_W = IF_W + 1;

    logic [PC_BITS-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_BITS-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IF_W-1:0]    inflight_q, inflight_d;
    logic [IF_W-1:0]    discard_q, discard_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]        word_mem [DEPTH];
    logic [PC_BITS-1:0] pc_mem   [DEPTH];

    logic [OCC_W-1:0]   occupancy;
    logic [PC_BITS-1:0] redirect_aligned;
    logic               credit;
    logic               req_valid;
    logic               req_fire;
    logic               resp_acc;
    logic               head_valid;
    logic               push;
    logic               pop;

    // Slots already claimed: buffered words plus non-stale outstanding fetches.
    // Stale fetches never land in the FIFO, so they do not consume credit.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(discard_q);
    // The all-ones guard only keeps the outstanding counter from wrapping.
    assign credit    = (occupancy < OCC_W'(DEPTH)) && (inflight_q != '1);
    assign req_valid = !rst && !bus.redirect_valid && credit;
    assign req_fire  = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_acc  = bus.imem_resp_valid && (inflight_q != '0);
    assign head_valid = (count_q != '0);
    assign redirect_aligned = bus.redirect_pc & ~PC_BITS'(3);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = head_valid ? word_mem[rd_ptr_q] : '0;
    assign bus.instr_pc       = head_valid ? pc_mem[rd_ptr_q]   : '0;

    // Next-state: a redirect overrides every other event in its cycle
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // No request fires this cycle; everything still outstanding is stale.
            inflight_d = inflight_q - IF_W'(resp_acc);
            discard_d  = inflight_q - IF_W'(resp_acc);
        end else begin
            push       = resp_acc && (discard_q == '0);
            pop        = head_valid && bus.instr_ready;
            inflight_d = inflight_q + IF_W'(req_fire) - IF_W'(resp_acc);
            if (resp_acc && (discard_q != '0)) begin
                discard_d = discard_q - IF_W'(1);
            end
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_BITS'(4);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + PC_BITS'(4);
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= bus.imem_resp_data;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a fixed-latency in-order memory.
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic rst;

  instr_fetch_queue_if #(.PC_BITS(32)) bus_if ();

  instr_fetch_queue #(
    .PC_BITS  (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] fired_q[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record an accepted fetch, advance, then drive the memory response.
  task automatic tick();
    logic        fired;
    logic [31:0] faddr;
    #1;
    fired = bus_if.imem_req_valid && bus_if.imem_req_ready;
    faddr = bus_if.imem_req_addr;
    @(posedge clk);
    #1;
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      bus_if.imem_resp_valid = 1'b0;
      bus_if.imem_resp_data  = '0;
    end else begin
      if (fired) begin
        mq_addr.push_back(faddr);
        mq_due.push_back(cyc + lat);
        fired_q.push_back(faddr);
      end
      cyc++;
      if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
        bus_if.imem_resp_valid = 1'b1;
        bus_if.imem_resp_data  = mem_word(mq_addr[0]);
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus_if.imem_resp_valid = 1'b0;
        bus_if.imem_resp_data  = '0;
      end
    end
    #1;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    bus_if.imem_req_ready  = 1'b0;
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = '0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_pc     = '0;
    bus_if.instr_ready     = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    fired_q.delete();
    exp_q.delete();
    @(posedge clk);
    #2;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    cyc = 0;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values and streaming at one word per cycle
    hold_reset();
    chk("rst_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    chk("rst_req_addr", bus_if.imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("rst_instr", bus_if.instr, 32'h0);
    chk("rst_instr_pc", bus_if.instr_pc, 32'h0);
    lat = 1;
    bus_if.imem_req_ready = 1'b1;
    bus_if.instr_ready    = 1'b1;
    release_reset();
    chk("t1_c0_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
    chk("t1_c0_req_addr", bus_if.imem_req_addr, 32'h0);
    tick();
    chk("t1_c1_req_addr", bus_if.imem_req_addr, 32'h4);
    chk("t1_c1_instr_valid", 32'(bus_if.instr_valid), 32'd0);
    for (int k = 2; k < 8; k++) begin
      tick();
      chk("t1_instr_valid", 32'(bus_if.instr_valid), 32'd1);
      chk("t1_instr_pc", bus_if.instr_pc, 32'(4 * (k - 2)));
      chk("t1_instr", bus_if.instr, mem_word(32'(4 * (k - 2))));
      chk("t1_req_addr", bus_if.imem_req_addr, 32'(4 * k));
    end

    // Decode stalled: queue fills with four words, then resumes without gaps
    hold_reset();
    lat = 1;
    bus_if.imem_req_ready = 1'b1;
    bus_if.instr_ready    = 1'b0;
    release_reset();
    for (int k = 1; k <= 8; k++) tick();
    chk("t2_full_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    chk("t2_full_head_pc", bus_if.instr_pc, 32'h0);
    chk("t2_fired_count", 32'(fired_q.size()), 32'd4);
    bus_if.instr_ready = 1'b1;
    #1;
    chk("t2_pop_cycle_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    tick();
    chk("t2_after_pop_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
    chk("t2_after_pop_req_addr", bus_if.imem_req_addr, 32'h10);
    chk("t2_c9_pc", bus_if.instr_pc, 32'h4);
    tick();
    chk("t2_c10_pc", bus_if.instr_pc, 32'h8);
    tick();
    chk("t2_c11_pc", bus_if.instr_pc, 32'hC);
    tick();
    chk("t2_c12_valid", 32'(bus_if.instr_valid), 32'd1);
    chk("t2_c12_pc", bus_if.instr_pc, 32'h10);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};
    chk("t2_fired_total", 32'(fired_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && fired_q.size() > 0) begin
      chk("t2_fire_order", fired_q.pop_front(), exp_q.pop_front());
    end

    // Redirect with two requests outstanding, memory latency 3
    hold_reset();
    lat = 3;
    bus_if.imem_req_ready = 1'b1;
    bus_if.instr_ready    = 1'b1;
    release_reset();
    tick();
    tick();
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h103;
    #1;
    chk("t3_redirect_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    tick();
    bus_if.redirect_valid = 1'b0;
    #1;
    chk("t3_c3_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
    chk("t3_c3_req_addr", bus_if.imem_req_addr, 32'h100);
    chk("t3_c3_instr_valid", 32'(bus_if.instr_valid), 32'd0);
    tick();
    chk("t3_c4_instr_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("t3_c4_req_addr", bus_if.imem_req_addr, 32'h104);
    tick();
    chk("t3_c5_instr_valid", 32'(bus_if.instr_valid), 32'd0);
    tick();
    chk("t3_c6_instr_valid", 32'(bus_if.instr_valid), 32'd0);
    tick();
    chk("t3_c7_instr_valid", 32'(bus_if.instr_valid), 32'd1);
    chk("t3_c7_instr_pc", bus_if.instr_pc, 32'h100);
    chk("t3_c7_instr", bus_if.instr, mem_word(32'h100));

    // Redirect coinciding with a response into a nearly full queue
    hold_reset();
    lat = 1;
    bus_if.imem_req_ready = 1'b1;
    bus_if.instr_ready    = 1'b0;
    release_reset();
    for (int k = 1; k <= 4; k++) tick();
    chk("t4_pre_valid", 32'(bus_if.instr_valid), 32'd1);
    chk("t4_pre_resp", 32'(bus_if.imem_resp_valid), 32'd1);
    bus_if.redirect_valid = 1'b1;
    bus_if.redirect_pc    = 32'h40;
    #1;
    chk("t4_redirect_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    tick();
    bus_if.redirect_valid = 1'b0;
    #1;
    chk("t4_flush_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("t4_flush_instr", bus_if.instr, 32'h0);
    chk("t4_flush_pc", bus_if.instr_pc, 32'h0);
    chk("t4_req_valid", 32'(bus_if.imem_req_valid), 32'd1);
    chk("t4_req_addr", bus_if.imem_req_addr, 32'h40);
    tick();
    chk("t4_c6_valid", 32'(bus_if.instr_valid), 32'd0);
    tick();
    chk("t4_c7_valid", 32'(bus_if.instr_valid), 32'd1);
    chk("t4_c7_pc", bus_if.instr_pc, 32'h40);
    chk("t4_c7_instr", bus_if.instr, mem_word(32'h40));

    // Memory not ready for five cycles: request held steady
    hold_reset();
    lat = 1;
    bus_if.imem_req_ready = 1'b1;
    bus_if.instr_ready    = 1'b1;
    release_reset();
    tick();
    tick();
    bus_if.imem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", 32'(bus_if.imem_req_valid), 32'd1);
      chk("t5_hold_addr", bus_if.imem_req_addr, 32'h8);
      tick();
    end
    bus_if.imem_req_ready = 1'b1;
    #1;
    chk("t5_accept_addr", bus_if.imem_req_addr, 32'h8);
    tick();
    chk("t5_next_addr", bus_if.imem_req_addr, 32'hC);
    chk("t5_c8_valid", 32'(bus_if.instr_valid), 32'd0);
    tick();
    chk("t5_c9_valid", 32'(bus_if.instr_valid), 32'd1);
    chk("t5_c9_pc", bus_if.instr_pc, 32'h8);

    // Asynchronous reset mid-stream
    hold_reset();
    lat = 1;
    bus_if.imem_req_ready = 1'b1;
    bus_if.instr_ready    = 1'b0;
    release_reset();
    for (int k = 1; k <= 4; k++) tick();
    chk("t6_pre_valid", 32'(bus_if.instr_valid), 32'd1);
    #1;
    rst = 1'b1;
    mq_addr.delete();
    mq_due.delete();
    bus_if.imem_resp_valid = 1'b0;
    bus_if.imem_resp_data  = '0;
    #1;
    chk("t6_async_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("t6_async_instr", bus_if.instr, 32'h0);
    chk("t6_async_pc", bus_if.instr_pc, 32'h0);
    chk("t6_async_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    chk("t6_async_req_addr", bus_if.imem_req_addr, 32'h0);
    tick();
    release_reset();
    chk("t6_restart_valid", 32'(bus_if.imem_req_valid), 32'd1);
    chk("t6_restart_addr", bus_if.imem_req_addr, 32'h0);
    tick();
    chk("t6_c1_addr", bus_if.imem_req_addr, 32'h4);
    tick();
    chk("t6_c2_valid", 32'(bus_if.instr_valid), 32'd1);
    chk("t6_c2_pc", bus_if.instr_pc, 32'h0);
    chk("t6_c2_instr", bus_if.instr, mem_word(32'h0));

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch-side producer of the raw instruction word consumed by the decode stage. It is the other end of the decoder's instruction input.
- Issues in-order word fetches to instruction memory and buffers returned words with their PCs in a small FIFO. Presents them to decode with a valid/ready handshake.
- Handles redirects from jumps/branches: flushes the queue and discards stale in-flight responses.

Parameters:
PC_BITS, 32, width of PC and memory address.
DEPTH, 4, queue entries; power of two, >= 2.
RESET_PC, 0, fetch address after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_addr  out  PC_BITS  fetch address, word aligned.
imem_req_ready  in  1  memory accepts request.
imem_resp_valid  in  1  response word valid; in request order; latency >= 1 cycle.
imem_resp_data  in  32  fetched instruction word.
redirect_valid  in  1  control-flow redirect (jump/taken branch).
redirect_pc  in  PC_BITS  new fetch PC; bits [1:0] ignored and treated as 0.
instr_valid  out  1  head entry available to decode.
instr  out  32  head instruction word; 0 when instr_valid=0, which decodes as invalid/stall.
instr_pc  out  PC_BITS  PC of head word; 0 when instr_valid=0.
instr_ready  in  1  decode consumes head.

Behaviour:
- State:
  - fetch_pc: next request address.
  - resp_pc: PC of next non-stale response.
  - count: 0..DEPTH.
  - inflight: outstanding requests.
  - discard: stale outstanding requests, always <= inflight.
  - FIFO storage of {word, pc}.
- Reset (async, while rst=1):
  - fetch_pc = resp_pc = RESET_PC; count = inflight = discard = 0.
  - All outputs 0 except imem_req_addr = RESET_PC.
  - The memory is reset together with this block, so no pre-reset responses arrive.
- Credit: imem_req_valid = !redirect_valid && (count + inflight - discard) < DEPTH. This guarantees every non-stale response has a free slot; the FIFO never overflows.
- Request fire (imem_req_valid && imem_req_ready): fetch_pc += 4 (wraps modulo 2^PC_BITS); inflight += 1.
- Request stability: once imem_req_valid is asserted, valid and addr hold until accepted. The only exception is a redirect, which may withdraw or change the request.
- Response handling (imem_resp_valid): inflight -= 1.
  - If discard > 0: word dropped, discard -= 1.
  - Otherwise: push {imem_resp_data, resp_pc}; resp_pc += 4.
  - imem_resp_valid with inflight == 0 is a protocol error and is ignored.
- Output:
  - instr_valid = (count != 0); instr/instr_pc driven from the FIFO head.
  - Pop when instr_valid && instr_ready.
  - Latency: response in cycle N gives instr_valid in cycle N+1 (no bypass).
- Simultaneous push and pop: count is unchanged, ordering is preserved, and a full queue with a pop accepts the push.
- Redirect (redirect_valid=1 in cycle N) takes priority over all other events in that cycle:
  - FIFO flushed (count=0); any same-cycle push or pop is ignored.
  - fetch_pc = resp_pc = redirect_pc & ~3.
  - No request is issued in cycle N.
  - discard = inflight - imem_resp_valid. Every outstanding request is stale, and a response arriving in cycle N is dropped.
  - First request to redirect_pc is issued in cycle N+1 if credit allows.
- Back-to-back redirects: the later one wins; discard accumulates correctly because each redirect recomputes it from inflight.
- The head entry popped in the redirect cycle is considered consumed. The decode stage is responsible for squashing it.

Test Plan:
1. Reset release, RESET_PC=0, memory latency 1, always ready, instr_ready=1 -> requests 0x0,0x4,0x8,... one per cycle; instr_pc sequence 0x0,0x4,...; first instr_valid 2 cycles after first request fire.
2. instr_ready=0, DEPTH=4 -> exactly 4 requests (0x0..0xC); imem_req_valid low while full; set instr_ready=1 -> next request addr 0x10 in the cycle after the first pop, with no gaps or duplicates.
3. Memory latency 3, redirect_pc=0x103 with 2 requests in flight -> next request addr 0x100; 2 stale responses dropped; first instr_valid shows instr_pc=0x100.
4. Redirect in the same cycle as a response and a full queue -> response dropped, count=0 next cycle, no request in redirect cycle.
5. imem_req_ready=0 for 5 cycles -> imem_req_addr held at 0x8 throughout; fetch_pc advances only after accept.
6. Assert rst asynchronously mid-stream with count=3, inflight=1 -> instr_valid/instr/instr_pc go to 0 before the next clock edge; after release, fetch restarts at RESET_PC.
